// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared mode encodings, BCD field limits and blink masks for
//                the BASYS3 digital clock timekeeping controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    // Mode encodings as seen on the mode output port
    localparam logic [1:0] MODE_RUN     = 2'b00;
    localparam logic [1:0] MODE_SET_HR  = 2'b01;
    localparam logic [1:0] MODE_SET_MIN = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN     = MODE_RUN,
        ST_SET_HR  = MODE_SET_HR,
        ST_SET_MIN = MODE_SET_MIN,
        ST_BAD     = 2'b11
    } mode_e;

    // Field limits stored as BCD tens/units pairs
    localparam logic [3:0] SEC_MAX_TENS  = 4'd5;
    localparam logic [3:0] SEC_MAX_UNITS = 4'd9;
    localparam logic [3:0] MIN_MAX_TENS  = 4'd5;
    localparam logic [3:0] MIN_MAX_UNITS = 4'd9;
    localparam logic [3:0] HR_MAX_TENS   = 4'd2;
    localparam logic [3:0] HR_MAX_UNITS  = 4'd3;

    // Blank masks, bit3 = leftmost digit
    localparam logic [3:0] BLANK_NONE = 4'b0000;
    localparam logic [3:0] BLANK_HR   = 4'b1100;
    localparam logic [3:0] BLANK_MIN  = 4'b0011;

    // True when a BCD pair sits exactly at its field limit
    function automatic logic bcd_at_limit(
        input logic [3:0] tens,
        input logic [3:0] units,
        input logic [3:0] max_tens,
        input logic [3:0] max_units
    );
        return (tens == max_tens) && (units == max_units);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mod_counter
//  Description : Two-digit BCD modulo counter. Counts 00 up to the pair
//                TENS_MAX/UNITS_MAX_AT_TENS_MAX, then wraps to 00 raising a
//                combinational carry. Synchronous zero has priority over inc.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [3:0] TENS_MAX              = 4'd5,
    parameter logic [3:0] UNITS_MAX_AT_TENS_MAX = 4'd9
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    input  logic       zero,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       carry
);

    logic [3:0] tens_q;
    logic [3:0] tens_d;
    logic [3:0] units_q;
    logic [3:0] units_d;
    logic       at_limit;

    // Next digit pair: clear, hold, or BCD increment with wrap at the limit
    always_comb begin
        tens_d   = tens_q;
        units_d  = units_q;
        at_limit = bcd_at_limit(tens_q, units_q, TENS_MAX, UNITS_MAX_AT_TENS_MAX);
        if (zero) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
        end else if (inc) begin
            if (at_limit) begin
                tens_d  = 4'd0;
                units_d = 4'd0;
            end else if (units_q == 4'd9) begin
                tens_d  = tens_q + 4'd1;
                units_d = 4'd0;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    // Digit registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens  = tens_q;
    assign units = units_q;
    assign carry = inc & at_limit;

endmodule
`default_nettype wire

// File: rtl/clock_time_controller.sv
`default_nettype none
// ============================================================================
//  Module      : clock_time_controller
//  Description : HH:MM:SS BCD timekeeper with run / set-hours / set-minutes
//                mode machine, one-second prescaler and per-digit blink mask
//                for a four-digit multiplexed seven-segment display.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_time_controller
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] dig_hr_t,
    output logic [3:0] dig_hr_u,
    output logic [3:0] dig_min_t,
    output logic [3:0] dig_min_u,
    output logic [3:0] blank,
    output logic [1:0] mode,
    output logic       sec_tick
);

    localparam int            PW         = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

    mode_e         mode_q;
    mode_e         mode_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          sec_tick_q;
    logic          sec_tick_d;
    logic [3:0]    blank_q;
    logic [3:0]    blank_d;

    logic          in_run;
    logic          edit_hr;
    logic          edit_min;
    logic          leave_set_min;
    logic          sec_inc;
    logic          min_inc;
    logic          hr_inc;
    logic          sec_carry;
    logic          min_carry;
    logic          hr_carry_unused;
    logic [3:0]    sec_tens_unused;
    logic [3:0]    sec_units_unused;

    // Mode sequencing; the unused encoding falls back to RUN
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            ST_RUN:     if (btn_mode) mode_d = ST_SET_HR;
            ST_SET_HR:  if (btn_mode) mode_d = ST_SET_MIN;
            ST_SET_MIN: if (btn_mode) mode_d = ST_RUN;
            default:    mode_d = ST_RUN;
        endcase
    end

    // Increment/carry routing; a mode press in the same cycle drops btn_inc
    always_comb begin
        in_run        = (mode_q == ST_RUN);
        edit_hr       = (mode_q == ST_SET_HR)  && btn_inc && !btn_mode;
        edit_min      = (mode_q == ST_SET_MIN) && btn_inc && !btn_mode;
        leave_set_min = (mode_q == ST_SET_MIN) && btn_mode;
        sec_inc       = in_run && sec_tick_q;
        min_inc       = (in_run && sec_carry) || edit_min;
        hr_inc        = (in_run && min_carry) || edit_hr;
    end

    // Prescaler, tick and blink next-state; registered outputs track the
    // values the prescaler and mode will hold after this edge
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (leave_set_min || (presc_q == PRESC_LAST)) begin
            presc_d = '0;
        end
        sec_tick_d = (presc_d == PRESC_LAST);
        blank_d    = BLANK_NONE;
        if (presc_d >= PRESC_HALF) begin
            if (mode_d == ST_SET_HR) begin
                blank_d = BLANK_HR;
            end else if (mode_d == ST_SET_MIN) begin
                blank_d = BLANK_MIN;
            end
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mode_q     <= ST_RUN;
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
            blank_q    <= BLANK_NONE;
        end else begin
            mode_q     <= mode_d;
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
            blank_q    <= blank_d;
        end
    end

    // Seconds are internal; cleared when an edit finishes so the minute
    // boundary starts fresh
    bcd_mod_counter #(
        .TENS_MAX              (SEC_MAX_TENS),
        .UNITS_MAX_AT_TENS_MAX (SEC_MAX_UNITS)
    ) u_sec (
        .clk   (clk),
        .clr   (clr),
        .inc   (sec_inc),
        .zero  (leave_set_min),
        .tens  (sec_tens_unused),
        .units (sec_units_unused),
        .carry (sec_carry)
    );

    bcd_mod_counter #(
        .TENS_MAX              (MIN_MAX_TENS),
        .UNITS_MAX_AT_TENS_MAX (MIN_MAX_UNITS)
    ) u_min (
        .clk   (clk),
        .clr   (clr),
        .inc   (min_inc),
        .zero  (1'b0),
        .tens  (dig_min_t),
        .units (dig_min_u),
        .carry (min_carry)
    );

    // Hours wrap 23 -> 00 with nothing above them to carry into
    bcd_mod_counter #(
        .TENS_MAX              (HR_MAX_TENS),
        .UNITS_MAX_AT_TENS_MAX (HR_MAX_UNITS)
    ) u_hr (
        .clk   (clk),
        .clr   (clr),
        .inc   (hr_inc),
        .zero  (1'b0),
        .tens  (dig_hr_t),
        .units (dig_hr_u),
        .carry (hr_carry_unused)
    );

    assign mode     = mode_q;
    assign sec_tick = sec_tick_q;
    assign blank    = blank_q;

endmodule
`default_nettype wire

// File: doc/clock_time_controller.md
# clock_time_controller

Timekeeping and set-mode controller for the BASYS3 digital clock. Counts hours, minutes and seconds in BCD from the 100 MHz board clock. Sequences a three-state run/set-hours/set-minutes mode machine driven by debounced button pulses. Supplies the four HH:MM digits, plus a per-digit blink mask, to the four-digit multiplexed seven-segment display driver.

## Interface
- CLK_HZ, 100_000_000, clock cycles per second; must be ≥ 2 (benches use 4).
- clk  in  1  system clock, all state on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- btn_mode  in  1  one-cycle pulse, synchronous to clk, debounced upstream; advances the mode.
- btn_inc  in  1  one-cycle pulse, synchronous to clk, debounced upstream; increments the field being set.
- dig_hr_t  out  4  hours tens BCD (0–2); leftmost display digit.
- dig_hr_u  out  4  hours units BCD (0–9).
- dig_min_t  out  4  minutes tens BCD (0–5).
- dig_min_u  out  4  minutes units BCD (0–9); rightmost display digit.
- blank  out  4  digit blank mask, bit3 = leftmost digit, 1 = blank.
- mode  out  2  current state: 00 RUN, 01 SET_HR, 10 SET_MIN.
- sec_tick  out  1  one-cycle pulse once per second.

## Operation
- Prescaler 0..CLK_HZ-1 free-runs in every state and wraps to 0.
- sec_tick is high in the cycle where prescaler = CLK_HZ-1.
- Time fields: sec 00–59 (internal only), min 00–59, hr 00–23, each stored as a BCD tens/units pair. No binary-to-BCD conversion.
- Field increment: units +1; units 9 → units 0 and tens +1; at field limit → 00 plus carry out.
- RUN behaviour:
  - sec_tick increments sec.
  - sec carry increments min.
  - min carry increments hr.
  - hr wraps 23 → 00 with no further carry.
  - 23:59:59 + tick → 00:00:00.
- FSM:
  - RUN → SET_HR on btn_mode.
  - SET_HR → SET_MIN on btn_mode.
  - SET_MIN → RUN on btn_mode.
  - Encoding 2'b11 is unreachable; if entered, go to RUN on the next clock.
- SET_HR: btn_inc increments hr modulo 24. min and sec are frozen.
- SET_MIN: btn_inc increments min modulo 60, with no carry into hr. sec is frozen.
- Leaving SET_MIN for RUN: sec and prescaler are cleared to 0 in the same edge, so the first tick arrives CLK_HZ cycles later.
- In RUN, btn_inc is ignored.
- Blink: the edited field's two blank bits are 1 while prescaler ≥ CLK_HZ/2.
  - SET_HR blinks bits 3:2.
  - SET_MIN blinks bits 1:0.
  - blank = 0000 in RUN.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: mode transition taken, inc dropped.
  - sec_tick and btn_mode in RUN: the tick is applied and the state moves to SET_HR.
  - sec_tick in SET states: time is not advanced.

## Timing
- All outputs are registered.
- A button pulse at edge N changes mode and digits at edge N, visible after N.
- A tick advances the time in the same edge that ends the tick cycle.
- Reset values (clr high, asynchronous):
  - digits 0,0,0,0; sec 0; prescaler 0.
  - mode 00 (RUN), blank 0000, sec_tick 0.
- clr mid-set aborts the edit and returns to RUN at 00:00.
- Release of clr is sampled on the next rising clk; the first tick comes CLK_HZ cycles after release.
- Button pulses longer than one cycle are each counted per cycle high; upstream guarantees single-cycle pulses.

## Structure
- Package clock_pkg holds:
  - mode localparams MODE_RUN, MODE_SET_HR, MODE_SET_MIN;
  - field limits SEC_MAX = 59, MIN_MAX = 59, HR_MAX = 23 as BCD tens/units pairs.
- Sub-module bcd_mod_counter, instantiated three times (sec, min, hr):
  - parameters TENS_MAX, UNITS_MAX_AT_TENS_MAX;
  - inputs clk, clr, inc, zero;
  - outputs tens[3:0], units[3:0], carry (combinational: inc & at-limit).
- Top level contains the prescaler, mode FSM, increment/carry routing and blink mask.

## Test plan
1. Reset, CLK_HZ=4, 240 cycles in RUN → digits 0,0,0,1 (00:01), sec_tick pulsed 60 times, blank 0000.
2. Preload via set mode to 23:59, exit to RUN, run 240 cycles → 00:00, with hr wrapping through the carry chain.
3. btn_mode, then 25 btn_inc pulses → mode 01, hr 01. blank bits 3:2 toggle with prescaler 2–3 high, 0–1 low; min unchanged.
4. In SET_MIN, btn_mode and btn_inc in the same cycle → mode 00, min unchanged, blank 0000.
5. In SET_MIN at 59, btn_inc → min 00, hr unchanged. Exit → prescaler 0, and the first sec_tick arrives exactly 4 cycles later.
6. Assert clr asynchronously between clock edges while in SET_HR at 14 → all outputs at reset values immediately, before the next clk edge.
